// File: rtl/pulse_stretcher.sv
// Turns single-cycle events into fixed-length high windows separated by a low gap.
// Build option PULSE_STRETCHER_QUEUE_EN: queue events that arrive during a window or gap.
//
// state | meaning
// IDLE  | waiting for an event, out low
// HOLD  | out high, timer counts down the window
// GAP   | out low, timer counts down the mandatory gap
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int QUEUE_DEPTH = 7,
  localparam int PW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pulse_in,
  output logic          out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          dropped
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          drop_n;
  logic          last_gap;

  assign last_gap = (state == GAP) && (timer == '0);

  always_comb begin
    state_n = state;
    timer_n = timer;
    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_n = HOLD;
          timer_n = TW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (timer == '0) begin
          state_n = GAP;
          timer_n = TW'(GAP_CYCLES - 1);
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      GAP: begin
        if (timer != '0) begin
          timer_n = timer - TW'(1);
        end else if ((pending != '0) || pulse_in) begin
          state_n = HOLD;
          timer_n = TW'(HOLD_CYCLES - 1);
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

`ifdef PULSE_STRETCHER_QUEUE_EN
  logic [PW-1:0] pending_n;
  logic          enq, deq;

  // A pulse in the last gap cycle with nothing queued starts the next window directly.
  assign deq = last_gap && (pending != '0);
  assign enq = pulse_in && (state != IDLE) && !(last_gap && (pending == '0));

  always_comb begin
    pending_n = pending;
    drop_n    = 1'b0;
    if (enq && !deq && (pending == PW'(QUEUE_DEPTH))) begin
      drop_n = 1'b1;
    end else if (enq && !deq) begin
      pending_n = pending + PW'(1);
    end else if (deq && !enq) begin
      pending_n = pending - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_n;
  end
`else
  assign pending = '0;
  assign drop_n  = pulse_in && (state != IDLE) && !last_gap;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      out     <= (state_n == HOLD);
      busy    <= (state_n != IDLE);
      dropped <= drop_n;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized bench for pulse_stretcher against a window-schedule reference model.
// Works with PULSE_STRETCHER_QUEUE_EN defined or undefined.
module tb_pulse_stretcher;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int QD   = 2;
`ifdef PULSE_STRETCHER_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_in = 1'b0;
  logic       out, busy, dropped;
  logic [1:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  // model: window start cycle, queued count, pending drop strobe
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_q      = 0;
  bit m_drop   = 1'b0;
  int cyc      = 0;

  pulse_stretcher #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .out(out), .busy(busy), .pending(pending), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_q      = 0;
    m_drop   = 1'b0;
  endtask

  task automatic model_step(input bit p);
    bit nd = 1'b0;
    if (!m_active) begin
      if (p) begin m_active = 1'b1; m_start = cyc + 1; end
    end else if (cyc - m_start == HOLD + GAP - 1) begin
      if (m_q > 0) begin
        m_start = cyc + 1;
        if (!p) m_q--;
      end else if (p) begin
        m_start = cyc + 1;
      end else begin
        m_active = 1'b0;
      end
    end else if (p) begin
      if (QEN && m_q < QD) m_q++;
      else nd = 1'b1;
    end
    m_drop = nd;
    cyc++;
  endtask

  task automatic check_outputs();
    bit e_out;
    e_out = m_active && ((cyc - m_start) < HOLD);
    chk("out", 32'(out), 32'(e_out));
    chk("busy", 32'(busy), 32'(m_active));
    chk("pending", 32'(pending), 32'(m_q));
    chk("dropped", 32'(dropped), 32'(m_drop));
  endtask

  task automatic cycle(input bit p);
    @(negedge clk);
    check_outputs();
    pulse_in = p;
    @(posedge clk);
    model_step(p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    model_reset();
    @(negedge clk);
    pulse_in = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int density;
    #2;
    chk("init_out", 32'(out), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_pending", 32'(pending), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    idle(3);
    cycle(1'b1); idle(10);                                  // single event
    cycle(1'b1); cycle(1'b0); cycle(1'b1); idle(14);        // queued pair
    cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b1);     // overflow
    idle(20);
    cycle(1'b1); idle(5); cycle(1'b1); idle(10);            // pulse in last gap cycle
    cycle(1'b1); cycle(1'b1); cycle(1'b1);                  // dequeue + enqueue when full
    idle(3); cycle(1'b1); idle(22);
    cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b0);     // reset mid-HOLD
    async_reset();
    idle(2); cycle(1'b1); idle(10);

    for (int blk = 0; blk < 30; blk++) begin
      density = $urandom_range(1, 8);
      for (int i = 0; i < 60; i++)
        cycle(($urandom_range(0, 9) < density) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 4) == 0) async_reset();
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Pulse-to-level driver: the output end of the button path.
- The button front end turns a held press into a single-cycle event; this block turns each single-cycle event back into a visible level (LED, buzzer, seven-segment blink).
- Each accepted event produces exactly one high window of fixed length, followed by a mandatory low gap, so back-to-back events stay distinguishable.
- A bounded pending counter queues events that arrive while a window or gap is in progress.

Parameters:
- HOLD_CYCLES, 25_000_000: clock cycles out stays high per event; must be >= 1.
- GAP_CYCLES, 12_500_000: clock cycles out stays low after each window before the next window may start; must be >= 1.
- QUEUE_DEPTH, 7: maximum queued events; must be >= 1. PW = $clog2(QUEUE_DEPTH+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pulse_in  input  1  event strobe, one cycle per event, synchronous to clk.
- out  output  1  stretched level, registered.
- busy  output  1  high whenever state is not IDLE, registered.
- pending  output  PW  number of queued events not yet displayed, registered.
- dropped  output  1  one-cycle strobe: an event was discarded, registered.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, timer=0, out=0, busy=0, pending=0, dropped=0. Reset mid-window aborts immediately and discards all pending events. After reset releases, the first pulse_in is accepted normally.
- FSM states: IDLE, HOLD, GAP. out==1 exactly when state==HOLD. A single down-counting timer is sized for max(HOLD_CYCLES, GAP_CYCLES).
- IDLE: pulse_in=1 at edge k -> HOLD from edge k+1, timer loaded with HOLD_CYCLES-1, pending unchanged. Latency from pulse_in to out rising is 1 cycle.
- HOLD: decrement timer; at timer==0 -> GAP with timer=GAP_CYCLES-1. out is high for exactly HOLD_CYCLES consecutive cycles.
- GAP: decrement timer; out low for exactly GAP_CYCLES cycles. At timer==0 (last gap cycle):
  - pending>0 -> HOLD, dequeue one event.
  - pending==0 and pulse_in=1 -> HOLD directly; pending stays 0.
  - otherwise -> IDLE.
- Enqueue: pulse_in=1 in HOLD, or in GAP not at the last cycle, is an enqueue request.
- Pending update: pending_next = pending + enq_accepted - deq. Simultaneous enqueue and dequeue leaves pending unchanged.
- Full queue: enqueue with pending==QUEUE_DEPTH and no dequeue in the same cycle -> event discarded, dropped=1 for one cycle (next cycle), pending unchanged. Enqueue while full but with a dequeue in the same cycle is accepted.
- pulse_in held high for multiple cycles counts as one event per cycle. Upstream guarantees single-cycle strobes; the block does not edge-detect.
- No counter wraps: pending saturates by design via the drop rule. The timer only reloads, never wraps.

Optional Feature:
- Macro: PULSE_STRETCHER_QUEUE_EN.
- Defined: queue behaviour as above.
- Undefined:
  - No queue. pending is tied to 0; QUEUE_DEPTH is ignored.
  - Any pulse_in in HOLD, or in GAP except the last gap cycle, is discarded with dropped=1 the next cycle.
  - A pulse in the last gap cycle still starts a new HOLD directly.
  - Pulse timing otherwise identical.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2, QUEUE_DEPTH=2, macro defined unless noted):
- Single event: pulse_in at cycle 10 -> out high cycles 11-14, low 15-16, busy high 11-16, busy low from 17, pending=0 throughout, dropped never.
- Queued pair: pulses at 10 and 12 -> pending=1 from 13. out high 11-14, low 15-16, high 17-20 with pending=0 from 17, low 21-22, IDLE from 23.
- Overflow: pulses at 10, 11, 12, 13 -> pending reaches 2 at 13. Pulse at 13 dropped, dropped=1 at cycle 14 only. Exactly three windows result.
- Boundary: pulse exactly in last gap cycle 16 with pending=0 -> out high 17-20, pending stays 0, no drop. With pending=2, a pulse at the dequeue cycle keeps pending=2 and sets no dropped.
- Reset mid-operation: pending=2, reset asserted mid-HOLD asynchronously -> out, busy, pending, dropped all 0 immediately. First pulse after release behaves as the single-event case.
- Macro undefined: pulses at 10 and 12 -> one window 11-14, dropped=1 at cycle 13, pending constantly 0.
